// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for onchip_mem_arbiter and its grant logic.
//   owner_e      : registered bus owner (IDLE, OWN0, OWN1)
//   NUM_MASTERS  : number of Avalon-MM masters sharing the RAM
//   HOLD_CNT_W   : width of the consecutive-grant (hold) counter
// ----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned HOLD_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1
    } owner_e;

endpackage

// File: rtl/rr_grant2.sv
// ----------------------------------------------------------------------------
// rr_grant2
// Combinational 2-way bounded-hold round-robin grant.
//   req      in  [NUM_MASTERS]  per-master request (read | write)
//   owner    in  owner_e        registered current owner
//   hold_cnt in  [HOLD_CNT_W]   consecutive grants given to the owner
//   prio_ptr in  1              master preferred on a tie from IDLE
//   locked   in  1              owner holds a lock (only with MEM_ARB_LOCK_EN)
//   grant    out [NUM_MASTERS]  one-hot grant, zero when nothing requests
// Optional feature macro: MEM_ARB_LOCK_EN adds the 'locked' input.
// ----------------------------------------------------------------------------
module rr_grant2
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  owner_e                 owner,
    input  logic [HOLD_CNT_W-1:0]  hold_cnt,
    input  logic                   prio_ptr,
`ifdef MEM_ARB_LOCK_EN
    input  logic                   locked,
`endif
    output logic [NUM_MASTERS-1:0] grant
);

    localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

    logic lock_hold;
    logic hold_ok;

`ifdef MEM_ARB_LOCK_EN
    assign lock_hold = locked;
`else
    assign lock_hold = 1'b0;
`endif

    assign hold_ok = hold_cnt < MAX_HOLD_C;

    always_comb begin
        grant = '0;
        case (owner)
            // A locked owner is the only candidate; the other master waits
            // even when the owner pauses between the locked accesses.
            OWN0: begin
                if (lock_hold)
                    grant[0] = req[0];
                else if (req[0] && (hold_ok || !req[1]))
                    grant[0] = 1'b1;
                else if (req[1])
                    grant[1] = 1'b1;
            end
            OWN1: begin
                if (lock_hold)
                    grant[1] = req[1];
                else if (req[1] && (hold_ok || !req[0]))
                    grant[1] = 1'b1;
                else if (req[0])
                    grant[0] = 1'b1;
            end
            default: begin
                if (&req)
                    grant[prio_ptr] = 1'b1;
                else
                    grant = req;
            end
        endcase
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// onchip_mem_arbiter
// Shares one single-port 1-cycle-latency RAM between two Avalon-MM masters
// (core0, core1) with bounded-hold round-robin arbitration, one access per
// cycle, and pipelined read return tagged to the issuing master.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   m0_* / m1_*             Avalon-MM slave side per master: address,
//                           byteenable, read, write, writedata, waitrequest,
//                           readdata, readdatavalid (+ lock, see below)
//   mem_*                   RAM port: address, byteenable, chipselect, write,
//                           writedata, clken (tied 1), readdata
// Optional feature macro: MEM_ARB_LOCK_EN adds m0_lock / m1_lock; a granted
// access with lock high keeps ownership until a granted access with lock low.
// ----------------------------------------------------------------------------
module onchip_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                m0_lock,
`endif
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,

    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
`ifdef MEM_ARB_LOCK_EN
    input  logic                m1_lock,
`endif
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,

    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);

    localparam logic [HOLD_CNT_W-1:0] MAX_HOLD_C = HOLD_CNT_W'(MAX_HOLD);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] grant_eff;
    owner_e                 owner;
    logic [HOLD_CNT_W-1:0]  hold_cnt;
    logic [HOLD_CNT_W-1:0]  hold_inc;
    logic                   prio_ptr;
    logic                   rd_pend;
    logic                   rd_tag;
    logic                   lock_q;
    logic                   sel1;
    logic                   sel_read;
    logic                   issue_read;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    rr_grant2 #(
        .MAX_HOLD (MAX_HOLD)
    ) u_grant (
        .req      (req),
        .owner    (owner),
        .hold_cnt (hold_cnt),
        .prio_ptr (prio_ptr),
`ifdef MEM_ARB_LOCK_EN
        .locked   (lock_q),
`endif
        .grant    (grant)
    );

    // Grant state is reset to IDLE, but grant itself is combinational from
    // req, so the bus is explicitly kept quiet while reset_n is low.
    assign grant_eff  = grant & {NUM_MASTERS{reset_n}};
    assign sel1       = grant[1];
    // A read wins over a (protocol-illegal) simultaneous write.
    assign sel_read   = sel1 ? m1_read : m0_read;
    assign issue_read = (|grant) & sel_read;
    assign hold_inc   = (hold_cnt < MAX_HOLD_C) ? hold_cnt + 1'b1 : hold_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner    <= IDLE;
            hold_cnt <= '0;
            prio_ptr <= 1'b0;
            rd_pend  <= 1'b0;
            rd_tag   <= 1'b0;
        end else begin
            rd_pend <= issue_read;
            rd_tag  <= sel1;
            if (grant[0]) begin
                owner    <= OWN0;
                prio_ptr <= 1'b1;
                hold_cnt <= (owner == OWN0) ? hold_inc : HOLD_CNT_W'(1);
            end else if (grant[1]) begin
                owner    <= OWN1;
                prio_ptr <= 1'b0;
                hold_cnt <= (owner == OWN1) ? hold_inc : HOLD_CNT_W'(1);
            end else if (!lock_q) begin
                owner    <= IDLE;
                hold_cnt <= '0;
            end
        end
    end

`ifdef MEM_ARB_LOCK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lock_q <= 1'b0;
        else if (grant[0])
            lock_q <= m0_lock;
        else if (grant[1])
            lock_q <= m1_lock;
    end
`else
    assign lock_q = 1'b0;
`endif

    assign mem_address    = sel1 ? m1_address    : m0_address;
    assign mem_byteenable = sel1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = sel1 ? m1_writedata  : m0_writedata;
    assign mem_chipselect = |grant_eff;
    assign mem_write      = mem_chipselect & ~sel_read & (sel1 ? m1_write : m0_write);
    assign mem_clken      = 1'b1;

    assign m0_waitrequest = (req[0] & ~grant[0]) | ~reset_n;
    assign m1_waitrequest = (req[1] & ~grant[1]) | ~reset_n;

    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdatavalid = rd_pend & ~rd_tag;
    assign m1_readdatavalid = rd_pend &  rd_tag;

    a_m0_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(m0_read && m0_write));
    a_m1_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(m1_read && m1_write));

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
// Self-checking bench for onchip_mem_arbiter with a behavioural RAM model.
// Define MEM_ARB_LOCK_EN to also exercise the lock sequence.
// ----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

    localparam int unsigned ADDR_W   = 13;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MAX_HOLD = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] m0_address = '0, m1_address = '0;
    logic [3:0]        m0_byteenable = '0, m1_byteenable = '0;
    logic              m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0]       m0_writedata = '0, m1_writedata = '0;
    logic              m0_waitrequest, m1_waitrequest;
    logic [31:0]       m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [31:0]       mem_writedata;
    logic [31:0]       mem_readdata;
`ifdef MEM_ARB_LOCK_EN
    logic              m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
`ifdef MEM_ARB_LOCK_EN
        .m0_lock          (m0_lock),
        .m1_lock          (m1_lock),
`endif
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Behavioural single-port RAM, one cycle read latency.
    logic [31:0] ram [8192];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: accepted reads push the expected word (from a shadow copy
    // built from accepted writes on the master side); the next cycle must
    // return exactly that word to exactly that master.
    typedef struct {
        int          cyc;
        logic        tag;
        logic [31:0] data;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] shadow [8192];

    always @(negedge clk) begin
        exp_t        e;
        logic        ev0, ev1;
        logic [31:0] edata;
        cyc++;
        if (!reset_n) begin
            sb.delete();
            check1("rst_rdvalid0", m0_readdatavalid, 1'b0);
            check1("rst_rdvalid1", m1_readdatavalid, 1'b0);
        end else begin
            ev0 = 1'b0;
            ev1 = 1'b0;
            edata = '0;
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                e = sb.pop_front();
                if (e.tag) ev1 = 1'b1; else ev0 = 1'b1;
                edata = e.data;
            end
            check1("rdvalid0", m0_readdatavalid, ev0);
            check1("rdvalid1", m1_readdatavalid, ev1);
            if (ev0) check32("rddata0", m0_readdata, edata);
            if (ev1) check32("rddata1", m1_readdata, edata);
            if (m0_write && !m0_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (m0_byteenable[b]) shadow[m0_address][8*b +: 8] = m0_writedata[8*b +: 8];
            if (m1_write && !m1_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (m1_byteenable[b]) shadow[m1_address][8*b +: 8] = m1_writedata[8*b +: 8];
            if (m0_read && !m0_waitrequest) sb.push_back('{cyc, 1'b0, shadow[m0_address]});
            if (m1_read && !m1_waitrequest) sb.push_back('{cyc, 1'b1, shadow[m1_address]});
        end
    end

    typedef struct {
        logic        r0, w0;
        logic [12:0] a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [12:0] a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        ew0, ew1, ecs, ewr;
        logic [12:0] ea;
    } vec_t;

    function automatic vec_t v(input logic r0, input logic w0, input logic [12:0] a0,
                               input logic [3:0] be0, input logic [31:0] d0,
                               input logic r1, input logic w1, input logic [12:0] a1,
                               input logic [3:0] be1, input logic [31:0] d1,
                               input logic ew0, input logic ew1, input logic ecs,
                               input logic ewr, input logic [12:0] ea);
        vec_t t;
        t.r0 = r0; t.w0 = w0; t.a0 = a0; t.be0 = be0; t.d0 = d0;
        t.r1 = r1; t.w1 = w1; t.a1 = a1; t.be1 = be1; t.d1 = d1;
        t.ew0 = ew0; t.ew1 = ew1; t.ecs = ecs; t.ewr = ewr; t.ea = ea;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        m0_read = t.r0; m0_write = t.w0; m0_address = t.a0; m0_byteenable = t.be0; m0_writedata = t.d0;
        m1_read = t.r1; m1_write = t.w1; m1_address = t.a1; m1_byteenable = t.be1; m1_writedata = t.d1;
    endtask

    task automatic set_idle();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        set_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    vec_t vt[$];

    initial begin
        int run0, run1, max0, max1;
        logic g;

        // Table: {m0 r,w,addr,be,data | m1 r,w,addr,be,data | exp wait0,wait1,cs,write,addr}
        vt.push_back(v(1'b0, 1'b1, 13'h010, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h010));
        vt.push_back(v(1'b1, 1'b0, 13'h010, 4'hF, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h010));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h000));
        vt.push_back(v(1'b0, 1'b1, 13'h020, 4'hF, 32'hAABBCCDD, 1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h020));
        vt.push_back(v(1'b0, 1'b1, 13'h020, 4'h2, 32'h00001100, 1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 13'h020));
        vt.push_back(v(1'b1, 1'b0, 13'h020, 4'hF, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h020));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h000));
        // tie from IDLE after core0 was last owner: core1 wins
        vt.push_back(v(1'b1, 1'b0, 13'h010, 4'hF, 32'h0,        1'b1, 1'b0, 13'h020, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h020));
        vt.push_back(v(1'b1, 1'b0, 13'h010, 4'hF, 32'h0,        1'b1, 1'b0, 13'h020, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h020));
        vt.push_back(v(1'b1, 1'b0, 13'h010, 4'hF, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h010));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h000));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b1, 13'h030, 4'hF, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, 13'h030));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b1, 1'b0, 13'h030, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h030));
        vt.push_back(v(1'b1, 1'b0, 13'h030, 4'hF, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h030));
        // both write the same word: core0 owns (hold 1 < MAX), core1 stalls then lands
        vt.push_back(v(1'b0, 1'b1, 13'h040, 4'h9, 32'hCAFEF00D, 1'b0, 1'b1, 13'h040, 4'h6, 32'h11223344, 1'b0, 1'b1, 1'b1, 1'b1, 13'h040));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b1, 13'h040, 4'h6, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b1, 13'h040));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b1, 1'b0, 13'h040, 4'hF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h040));
        vt.push_back(v(1'b0, 1'b0, 13'h000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h000, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h000));

        // Reset state with requests present
        m0_read = 1'b1;
        m1_write = 1'b1;
        @(negedge clk);
        check1("reset_wait0", m0_waitrequest, 1'b1);
        check1("reset_wait1", m1_waitrequest, 1'b1);
        check1("reset_cs",    mem_chipselect, 1'b0);
        check1("reset_write", mem_write,      1'b0);
        check1("reset_clken", mem_clken,      1'b1);
        @(posedge clk); #1;
        set_idle();
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (vt[i]) begin
            @(posedge clk); #1;
            drive(vt[i]);
            @(negedge clk);
            check1($sformatf("vec%0d_wait0", i), m0_waitrequest, vt[i].ew0);
            check1($sformatf("vec%0d_wait1", i), m1_waitrequest, vt[i].ew1);
            check1($sformatf("vec%0d_cs", i),    mem_chipselect, vt[i].ecs);
            check1($sformatf("vec%0d_write", i), mem_write,      vt[i].ewr);
            if (vt[i].ecs)
                check32($sformatf("vec%0d_addr", i), 32'(mem_address), 32'(vt[i].ea));
        end

        // Contention from reset: grants 0,0,0,0,1,1,1,1,...
        apply_reset();
        run0 = 0; run1 = 0; max0 = 0; max1 = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            m0_read = 1'b1; m0_address = 13'h010;
            m1_read = 1'b1; m1_address = 13'h020;
            @(negedge clk);
            g = ((k / 4) % 2) == 1;
            check1($sformatf("cont%0d_wait0", k), m0_waitrequest, g);
            check1($sformatf("cont%0d_wait1", k), m1_waitrequest, !g);
            run0 = m0_waitrequest ? run0 + 1 : 0;
            run1 = m1_waitrequest ? run1 + 1 : 0;
            if (run0 > max0) max0 = run0;
            if (run1 > max1) max1 = run1;
        end
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check32("cont_max_wait0", 32'(max0), 32'(MAX_HOLD));
        check32("cont_max_wait1", 32'(max1), 32'(MAX_HOLD));

        // Reset in the cycle after a read grant: no stray readdatavalid
        @(posedge clk); #1;
        m0_read = 1'b1; m0_address = 13'h020;
        @(negedge clk);
        check1("rstmid_grant", m0_waitrequest, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        check1("rstmid_rdvalid0", m0_readdatavalid, 1'b0);
        check1("rstmid_wait0",    m0_waitrequest,   1'b1);
        check1("rstmid_wait1",    m1_waitrequest,   1'b1);
        check1("rstmid_cs",       mem_chipselect,   1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check1("rstrel_wait0",    m0_waitrequest,   1'b0);
        check1("rstrel_cs",       mem_chipselect,   1'b1);
        check1("rstrel_rdvalid0", m0_readdatavalid, 1'b0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        check1("rstrel_ret_valid", m0_readdatavalid, 1'b1);
        check32("rstrel_ret_data", m0_readdata, 32'hAABB11DD);

`ifdef MEM_ARB_LOCK_EN
        // Locked run longer than MAX_HOLD, released by an unlocked write
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            m1_read = 1'b1; m1_address = 13'h020;
            m0_lock = (k < 5);
            m0_read = (k < 5); m0_write = (k == 5);
            m0_address = (k < 5) ? 13'h010 : 13'h050;
            m0_byteenable = 4'hF; m0_writedata = 32'h0BADCAFE;
            @(negedge clk);
            check1($sformatf("lock%0d_wait0", k), m0_waitrequest, 1'b0);
            check1($sformatf("lock%0d_wait1", k), m1_waitrequest, 1'b1);
        end
        @(posedge clk); #1;
        m0_read = 1'b0; m0_write = 1'b0; m0_lock = 1'b0;
        @(negedge clk);
        check1("lock_release_wait1", m1_waitrequest, 1'b0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
`endif

        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (8192 x 32, byte-enabled, 1-cycle read latency) between two Avalon-MM masters: core0 and core1 data masters.
- Issues at most one access per cycle, with bounded-hold round-robin arbitration.
- Returns pipelined read data with readdatavalid to the owning master.
- Sits between the two core interconnect ports and the RAM slave port.

Parameters:
- ADDR_W, 13, word address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- MAX_HOLD, 4, max consecutive grants to one master while the other requests; range 1..15.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low
- m0_address  in  ADDR_W  core0 word address
- m0_byteenable  in  DATA_W/8  core0 byte lanes
- m0_read  in  1  core0 read request
- m0_write  in  1  core0 write request
- m0_writedata  in  DATA_W  core0 write data
- m0_waitrequest  out  1  core0 stall
- m0_readdata  out  DATA_W  core0 read data
- m0_readdatavalid  out  1  core0 read data strobe
- m1_*  same set as m0_*, for core1
- mem_address  out  ADDR_W  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_chipselect  out  1  to RAM
- mem_write  out  1  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_clken  out  1  RAM clock enable, constant 1
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Request: req[i] = mi_read | mi_write. Both asserted together is illegal; a read wins and an assertion is raised.
- Grant is combinational from req, the owner register and the hold counter.
  - Exactly one grant when any request is present.
  - grant[i] drives mem_* from master i, with mem_chipselect = 1.
  - mi_waitrequest = req[i] & ~grant[i], or 1 while reset_n is low.
- Owner state: IDLE, OWN0, OWN1.
  - IDLE: the lower-priority-last master wins. prio_ptr is 0 after reset, so core0 wins a tie.
  - OWNi: master i keeps the grant while req[i] and hold_cnt < MAX_HOLD.
  - If the other master requests and hold_cnt == MAX_HOLD, or req[i] drops, the grant passes to the other master (OWNj, hold_cnt = 1).
  - If no requests are present, go to IDLE.
  - prio_ptr points away from the last owner.
- hold_cnt: 4-bit; increments per granted access; reset to 1 on an owner change; saturates at MAX_HOLD when uncontested.
- Write: completes in its grant cycle, with zero wait states on an uncontested bus.
- Read: issued in its grant cycle.
  - rd_pend and rd_tag are registered.
  - Next cycle: mi_readdatavalid = rd_pend & (rd_tag == i), and mi_readdata = mem_readdata for both masters.
  - Back-to-back reads are fully pipelined, one per cycle.
- Throughput: 1 access/cycle. Read latency is 1 cycle from the grant edge, plus arbitration stall.
- Outputs in reset: mem_chipselect 0, mem_write 0, all readdatavalid 0, all waitrequest 1, owner IDLE, hold_cnt 0, prio_ptr 0.
- Reset mid-read: the pending readdatavalid is dropped, never emitted after reset release.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- When defined: adds inputs m0_lock and m1_lock.
  - If mi_lock is high during a granted access, master i keeps ownership regardless of MAX_HOLD until a granted access with lock low.
  - Used for atomic read-modify-write.
  - The other master stalls, with waitrequest held high.
- When undefined: the lock ports are absent and arbitration is purely bounded round-robin.

Decomposition:
- Package mem_arb_pkg:
  - owner_e enum {IDLE, OWN0, OWN1}.
  - Constants: NUM_MASTERS = 2, HOLD_CNT_W = 4.
- One sub-module, rr_grant2: combinational 2-way grant from req, owner, hold_cnt, prio_ptr (and lock when enabled).
- Top-level module: registers, read-return tag, and mux.

Test Plan:
- Single master: core0 writes 0xDEADBEEF to addr 0x0010 with be=0xF, then reads addr 0x0010. Expect 0 wait states and readdatavalid one cycle after the read grant with data 0xDEADBEEF; m1_readdatavalid stays 0.
- Byte lanes: write 0xAABBCCDD, then be=0x2 with data 0x00001100, then read. Expect 0xAABB11DD.
- Contention, MAX_HOLD=4: both masters issue continuous reads from reset. Expect grants 0,0,0,0,1,1,1,1,0…, a waitrequest duration ≤ 4 cycles, and each readdatavalid tagged to the correct master.
- Simultaneous first request in IDLE: core0 wins. After core0 finishes, the next simultaneous request goes to core1 via prio_ptr.
- Reset mid-operation: assert reset_n low in the cycle after a read grant. Expect no readdatavalid, waitrequest=1, chipselect=0; after release, the first access is served normally.
- MEM_ARB_LOCK_EN: core0 does a read with lock, then a write with lock low, while core1 requests throughout. Expect core1 stalled for both accesses, and the core1 grant in the following cycle.
